// File: rtl/sap_control_sequencer.sv
// Six-phase T-state control sequencer for a SAP-style 4-bit-address datapath.
// Optional debug single-stepping is compiled in with `define SINGLE_STEP_EN.
module sap_control_sequencer #(
  parameter int T_STATES = 6,
  parameter int OPCODE_W = 4
) (
  input  logic                enable_in,
  input  logic                reset,
  input  logic                i_debug,
  input  logic                step_in,
  input  logic [OPCODE_W-1:0] ir_opcode,
  output logic [T_STATES-1:0] t_state,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                out_load,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  typedef enum logic [2:0] {
    S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  state_e state;
  logic   advance;

`ifdef SINGLE_STEP_EN
  logic step_q;

  // In debug mode only a fresh rising edge of step_in lets the ring move.
  assign advance = !i_debug || (step_in && !step_q);

  always_ff @(posedge enable_in or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step_in;
  end
`else
  logic unused_step;

  assign advance     = 1'b1;
  assign unused_step = ^{i_debug, step_in};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch abandons any instruction at once.
  always_ff @(posedge enable_in or negedge reset) begin
    if (!reset) begin
      state <= S_T1;
    end else if (advance) begin
      case (state)
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= (ir_opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        default: state <= S_HALT;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    t_state  = '0;
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    halted   = 1'b0;
    case (state)
      S_T1: begin
        t_state[0] = 1'b1;
        pc_out     = 1'b1;
        mar_load   = 1'b1;
      end
      S_T2: begin
        t_state[1] = 1'b1;
        pc_inc     = 1'b1;
      end
      S_T3: begin
        t_state[2] = 1'b1;
        ram_out    = 1'b1;
        ir_load    = 1'b1;
      end
      S_T4: begin
        t_state[3] = 1'b1;
        if (ir_opcode == OP_LDA || ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
          ir_out   = 1'b1;
          mar_load = 1'b1;
        end else if (ir_opcode == OP_OUT) begin
          a_out    = 1'b1;
          out_load = 1'b1;
        end
      end
      S_T5: begin
        t_state[4] = 1'b1;
        if (ir_opcode == OP_LDA) begin
          ram_out = 1'b1;
          a_load  = 1'b1;
        end else if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
          ram_out = 1'b1;
          b_load  = 1'b1;
          alu_sub = (ir_opcode == OP_SUB);
        end
      end
      S_T6: begin
        t_state[5] = 1'b1;
        if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
          alu_out = 1'b1;
          a_load  = 1'b1;
          alu_sub = (ir_opcode == OP_SUB);
        end
      end
      default: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed instruction scenarios
// plus randomized opcode/debug stimulus against a phase-counter reference model.
module tb_sap_control_sequencer;

  logic       enable_in = 1'b0;
  logic       reset     = 1'b0;
  logic       i_debug   = 1'b0;
  logic       step_in   = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 1..6 = T1..T6, phase 0 = halted.
  int   m_phase     = 1;
  logic m_step_prev = 1'b0;

  sap_control_sequencer dut (
    .enable_in(enable_in), .reset(reset), .i_debug(i_debug), .step_in(step_in),
    .ir_opcode(ir_opcode), .t_state(t_state), .pc_out(pc_out), .pc_inc(pc_inc),
    .mar_load(mar_load), .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_load(out_load), .halted(halted)
  );

  always #5 enable_in = ~enable_in;

  // Bit positions inside the 12-bit control word.
  localparam int PC_OUT = 11, PC_INC = 10, MAR_LOAD = 9, RAM_OUT = 8, IR_LOAD = 7;
  localparam int IR_OUT = 6, A_LOAD = 5, A_OUT = 4, B_LOAD = 3, ALU_OUT = 2;
  localparam int ALU_SUB = 1, OUT_LOAD = 0;

  wire [18:0] obs = {t_state, halted, pc_out, pc_inc, mar_load, ram_out, ir_load,
                     ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load};
  wire [2:0]  drivers = 3'(pc_out) + 3'(ram_out) + 3'(ir_out) + 3'(a_out) + 3'(alu_out);

  // Expected {t_state, halted, control word} from the instruction-set table.
  function automatic logic [18:0] expect_word(input int phase, input logic [3:0] op);
    logic [11:0] c;
    logic [5:0]  t;
    c = '0;
    if (phase == 0) return {6'b0, 1'b1, 12'b0};
    t = 6'b1 << (phase - 1);
    case (phase)
      1: begin c[PC_OUT] = 1; c[MAR_LOAD] = 1; end
      2: c[PC_INC] = 1;
      3: begin c[RAM_OUT] = 1; c[IR_LOAD] = 1; end
      4: if (op <= 4'd2) begin c[IR_OUT] = 1; c[MAR_LOAD] = 1; end
         else if (op == 4'hE) begin c[A_OUT] = 1; c[OUT_LOAD] = 1; end
      5: if (op == 4'd0) begin c[RAM_OUT] = 1; c[A_LOAD] = 1; end
         else if (op == 4'd1 || op == 4'd2) begin
           c[RAM_OUT] = 1; c[B_LOAD] = 1; c[ALU_SUB] = (op == 4'd2);
         end
      6: if (op == 4'd1 || op == 4'd2) begin
           c[ALU_OUT] = 1; c[A_LOAD] = 1; c[ALU_SUB] = (op == 4'd2);
         end
      default: ;
    endcase
    return {t, 1'b0, c};
  endfunction

  // One clock edge: update the model from the inputs seen at the edge.
  task automatic tick();
    logic moves;
    @(posedge enable_in);
`ifdef SINGLE_STEP_EN
    moves = !i_debug || (step_in && !m_step_prev);
`else
    moves = 1'b1;
`endif
    if (moves && m_phase != 0) begin
      if (m_phase == 4 && ir_opcode == 4'hF) m_phase = 0;
      else m_phase = (m_phase % 6) + 1;
    end
    m_step_prev = step_in;
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    m_phase = 1;
    m_step_prev = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #20;
    checks++;
    if (obs !== expect_word(1, ir_opcode)) begin
      errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, expect_word(1, ir_opcode));
    end
    reset = 1'b1;
    m_phase = 1;
    m_step_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== expect_word(m_phase, ir_opcode)) begin
        errors++; $display("FAIL reset_ring%0d obs=%h exp=%h", i, obs, expect_word(m_phase, ir_opcode));
      end
    end
    checks++;
    if (t_state !== 6'b000001) begin
      errors++; $display("FAIL reset_wrap t_state=%b exp=000001", t_state);
    end
  endtask

  // Runs one full instruction from T1; opcode is noise until T4.
  task automatic test_instruction(input logic [3:0] op, input string name);
    for (int k = 0; k < 6; k++) begin
      ir_opcode = (m_phase >= 4 || m_phase == 0) ? op : 4'($urandom);
      #1;
      checks++;
      if (obs !== expect_word(m_phase, ir_opcode)) begin
        errors++; $display("FAIL %s_p%0d obs=%h exp=%h", name, m_phase, obs, expect_word(m_phase, ir_opcode));
      end
      checks++;
      if (drivers > 3'd1) begin
        errors++; $display("FAIL %s_bus drivers=%0d exp<=1", name, drivers);
      end
      if (m_phase == 6 && (op == 4'd1 || op == 4'd2)) begin
        checks++;
        if (alu_sub !== (op == 4'd2) || alu_out !== 1'b1 || a_load !== 1'b1) begin
          errors++; $display("FAIL %s_t6 alu_sub=%b alu_out=%b a_load=%b", name, alu_sub, alu_out, a_load);
        end
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    test_instruction(4'hF, "hlt");
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== {6'b0, 1'b1, 12'b0} || m_phase != 0) begin
        errors++; $display("FAIL hlt_hold%0d obs=%h exp=%h", i, obs, {6'b0, 1'b1, 12'b0});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0 || pc_out !== 1'b1) begin
      errors++; $display("FAIL hlt_reset t_state=%b halted=%b exp=000001/0", t_state, halted);
    end
    reset = 1'b1;
    m_phase = 1;
    m_step_prev = 1'b0;
  endtask

  task automatic test_reset_mid();
    ir_opcode = 4'd1;
    while (m_phase != 5) tick();
    #1;
    checks++;
    if (b_load !== 1'b1 || t_state !== 6'b010000) begin
      errors++; $display("FAIL mid_t5 b_load=%b t_state=%b exp=1/010000", b_load, t_state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (t_state !== 6'b000001 || b_load !== 1'b0 || mar_load !== 1'b1) begin
      errors++; $display("FAIL mid_reset t_state=%b b_load=%b exp=000001/0", t_state, b_load);
    end
    reset = 1'b1;
    m_phase = 1;
    m_step_prev = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] cur_op = 4'd0;
    int prev_phase = 1;
    for (int i = 0; i < 300; i++) begin
      i_debug = 1'($urandom);
      step_in = 1'($urandom);
      if (m_phase == 4 && prev_phase != 4) cur_op = 4'($urandom_range(0, 14));
      ir_opcode = (m_phase <= 3) ? 4'($urandom) : cur_op;
      #1;
      checks++;
      if (obs !== expect_word(m_phase, ir_opcode) || drivers > 3'd1) begin
        errors++; $display("FAIL rand%0d obs=%h exp=%h", i, obs, expect_word(m_phase, ir_opcode));
      end
      prev_phase = m_phase;
      tick();
    end
    i_debug = 1'b0;
    step_in = 1'b0;
    pulse_reset();
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    i_debug = 1'b1;
    step_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (t_state !== 6'b000001) begin
        errors++; $display("FAIL step_idle%0d t_state=%b exp=000001", i, t_state);
      end
    end
    step_in = 1'b1;
    tick();
    checks++;
    if (t_state !== 6'b000010 || pc_inc !== 1'b1) begin
      errors++; $display("FAIL step_one t_state=%b exp=000010", t_state);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (t_state !== 6'b000010 || obs !== expect_word(m_phase, ir_opcode)) begin
        errors++; $display("FAIL step_held%0d t_state=%b exp=000010", i, t_state);
      end
    end
    i_debug = 1'b0;
    step_in = 1'b0;
    tick();
    checks++;
    if (t_state !== 6'b000100) begin
      errors++; $display("FAIL step_freerun t_state=%b exp=000100", t_state);
    end
    pulse_reset();
  endtask
`else
  task automatic test_debug_ignored();
    i_debug = 1'b1;
    step_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (t_state !== 6'b001000 || m_phase != 4) begin
      errors++; $display("FAIL dbg_ignored t_state=%b exp=001000", t_state);
    end
    i_debug = 1'b0;
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_instruction(4'd0, "lda");
    test_instruction(4'd2, "sub");
    test_instruction(4'd1, "add");
    test_instruction(4'hE, "out");
    test_instruction(4'h7, "nop");
    test_hlt();
    test_reset_mid();
`ifdef SINGLE_STEP_EN
    test_step();
`else
    test_debug_ignored();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control sequencer for the 4-bit-address SAP-style datapath: program counter, memory address register, RAM, instruction register, A/B registers, ALU and output register.
- Steps a fixed 6-phase T-state ring (3 fetch, 3 execute).
- Decodes the instruction register's opcode into a one-cycle control word that drives the MAR load, bus drivers and register loads.
- Owns the HALT condition and debug single-stepping.

Parameters:
- T_STATES, 6, number of T-states per instruction; fixed at 6, not legal to change.
- OPCODE_W, 4, width of ir_opcode.

Ports:
- enable_in  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_debug  input  1  1 = debug/step mode (see Optional Feature); 0 = free-run.
- step_in  input  1  step request, level, synchronous to enable_in.
- ir_opcode  input  4  upper nibble of the instruction register.
- t_state  output  6  one-hot current T-state; bit0 = T1.
- pc_out  output  1  PC drives the bus.
- pc_inc  output  1  PC increments.
- mar_load  output  1  MAR captures the bus address.
- ram_out  output  1  RAM drives the bus.
- ir_load  output  1  IR loads from the bus.
- ir_out  output  1  IR operand nibble drives the bus.
- a_load  output  1  A loads from the bus.
- a_out  output  1  A drives the bus.
- b_load  output  1  B loads from the bus.
- alu_out  output  1  ALU drives the bus.
- alu_sub  output  1  ALU subtracts (0 = add).
- out_load  output  1  output register loads.
- halted  output  1  sequencer stopped.

Behaviour:
- Reset (reset=0, asynchronous): t_state=6'b000001 (T1), halted=0, and the internal step-edge register is cleared. The control word follows from T1 (pc_out=1, mar_load=1). Reset mid-instruction abandons the instruction immediately.
- FSM states T1..T6 and HALT. Each advance moves one state per enabled edge: T1→T2→…→T6→T1.
- HALT is entered from T4 when the opcode is HLT. It is held until reset. In HALT: t_state=0, all control outputs 0, halted=1.
- Control outputs are combinational from the current state and ir_opcode. There is no extra latency; a signal is asserted for exactly the cycle(s) its T-state is active.
- Only one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) may be active in any state.
- Fetch phases (opcode-independent):
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute phases by opcode:
  - LDA 0000: T4 ir_out+mar_load; T5 ram_out+a_load; T6 none.
  - ADD 0001: T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load, alu_sub=0.
  - SUB 0010: as ADD, with alu_sub=1 in T5 and T6.
  - OUT 1110: T4 a_out+out_load; T5/T6 none.
  - HLT 1111: T4 no control signals; next state is HALT.
  - All other opcodes: NOP, T4–T6 idle.
- ir_opcode is sampled combinationally in T4–T6. It is stable because ir_load occurs only in T3.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - When i_debug=1, the FSM advances only on the edge after a 0→1 transition of step_in, detected with a registered copy. Exactly one advance per rising step_in.
  - Outputs hold the current state's control word while waiting, so load strobes stay high across stalled cycles. The datapath treats repeated loads as idempotent.
  - When i_debug=0, the sequencer free-runs.
  - Switching i_debug mid-instruction takes effect on the next edge.
- Undefined: step_in and i_debug are ignored and the sequencer always free-runs.

Test Plan:
- Reset: hold reset=0 for 20 time units, release → t_state=000001, pc_out=1, mar_load=1, halted=0; after 6 edges t_state returns to 000001.
- LDA: ir_opcode=0000 → T4 ir_out=mar_load=1; T5 ram_out=a_load=1; T6 all control 0; no overlapping bus drivers in any state.
- SUB then ADD: ir_opcode=0010 → T6 alu_out=a_load=alu_sub=1; with ir_opcode=0001, alu_sub=0 in T6.
- HLT: ir_opcode=1111 → after T4, halted=1, t_state=0, all outputs 0 for 10 further edges; reset=0 pulse → T1, halted=0.
- Reset mid-operation: assert reset=0 asynchronously during T5 of ADD → t_state=000001 immediately, with no clock edge needed; b_load deasserts at once.
- Single step (SINGLE_STEP_EN, i_debug=1): step_in held 0 for 5 edges → t_state stays 000001; one step_in pulse → exactly one advance to 000010; step_in held high → no further advance.
